// File: rtl/jt5205_feeder.sv
// ADPCM nibble feeder for an MSM5205-style decoder: streams bytes from sample ROM
// and hands one nibble to the decoder on every irq strobe, with one byte prefetched.
module jt5205_feeder #(
  parameter int AW         = 16,
  parameter int HIGH_FIRST = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  input  logic [AW-1:0] start_addr,
  input  logic [AW-1:0] end_addr,
  input  logic          irq,
  output logic [3:0]    din,
  output logic          busy,
  output logic          done,
  output logic          underrun,
  output logic [AW-1:0] rom_addr,
  output logic          rom_cs,
  input  logic [7:0]    rom_data,
  input  logic          rom_ok
);

  typedef enum logic [1:0] {IDLE, PRIME, PLAY} state_t;

  state_t        state;
  logic [AW-1:0] addr;
  logic [AW-1:0] last;
  logic [7:0]    cur;
  logic          cur_valid;
  logic [7:0]    next_byte;
  logic          next_valid;
  logic          half;
  logic          more;
  logic          armed;

  logic          accept;
  logic          want_fetch;
  logic          cur_free;
  logic [3:0]    first_nib;
  logic [3:0]    second_nib;

  // armed is low for the first cycle of every request, so a rom_ok left over
  // from the previous address can never be taken as valid data.
  assign accept     = rom_cs && armed && rom_ok;
  assign first_nib  = (HIGH_FIRST != 0) ? cur[7:4] : cur[3:0];
  assign second_nib = (HIGH_FIRST != 0) ? cur[3:0] : cur[7:4];

  always_comb begin
    want_fetch = 1'b0;
    if (more) begin
      if (state == PRIME)
        want_fetch = !cur_valid;
      else if (state == PLAY)
        want_fetch = !cur_valid || !next_valid;
    end
  end

  // A byte lands in cur when cur is empty or is being emptied by this very strobe
  assign cur_free = !cur_valid || (irq && half && !next_valid);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      addr       <= '0;
      last       <= '0;
      cur        <= '0;
      cur_valid  <= 1'b0;
      next_byte  <= '0;
      next_valid <= 1'b0;
      half       <= 1'b0;
      more       <= 1'b0;
      armed      <= 1'b0;
      din        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      underrun   <= 1'b0;
      rom_addr   <= '0;
      rom_cs     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        state      <= IDLE;
        busy       <= 1'b0;
        rom_cs     <= 1'b0;
        armed      <= 1'b0;
        din        <= '0;
        cur_valid  <= 1'b0;
        next_valid <= 1'b0;
        half       <= 1'b0;
        more       <= 1'b0;
      end else if (start) begin
        state      <= PRIME;
        addr       <= start_addr;
        last       <= end_addr;
        more       <= 1'b1;
        underrun   <= 1'b0;
        busy       <= 1'b1;
        rom_cs     <= 1'b0;
        armed      <= 1'b0;
        din        <= '0;
        cur_valid  <= 1'b0;
        next_valid <= 1'b0;
        half       <= 1'b0;
      end else begin
        if (rom_cs) begin
          if (!armed) begin
            armed <= 1'b1;
          end else if (rom_ok) begin
            rom_cs <= 1'b0;
            armed  <= 1'b0;
            addr   <= addr + AW'(1);
            if (addr == last)
              more <= 1'b0;
          end
        end else if (want_fetch) begin
          rom_cs   <= 1'b1;
          rom_addr <= addr;
          armed    <= 1'b0;
        end

        case (state)
          PRIME: begin
            if (irq)
              underrun <= 1'b1;
            if (accept) begin
              cur       <= rom_data;
              cur_valid <= 1'b1;
              half      <= 1'b0;
              state     <= PLAY;
            end
          end

          PLAY: begin
            if (irq) begin
              if (!cur_valid) begin
                din <= '0;
                if (more || next_valid) begin
                  underrun <= 1'b1;
                end else begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= IDLE;
                end
              end else if (!half) begin
                din  <= first_nib;
                half <= 1'b1;
              end else begin
                din  <= second_nib;
                half <= 1'b0;
                if (next_valid) begin
                  cur        <= next_byte;
                  next_valid <= 1'b0;
                end else begin
                  cur_valid <= 1'b0;
                  if (more)
                    underrun <= 1'b1;
                end
              end
            end
            // Placed after the strobe logic so a byte arriving with the strobe wins
            if (accept) begin
              if (cur_free) begin
                cur       <= rom_data;
                cur_valid <= 1'b1;
                half      <= 1'b0;
              end else begin
                next_byte  <= rom_data;
                next_valid <= 1'b1;
              end
            end
          end

          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jt5205_feeder.sv
// Directed bench for jt5205_feeder: behavioural ROM with adjustable latency, periodic
// irq strobes and hand-computed nibble sequences for both nibble orders.
module tb_jt5205_feeder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        irq = 1'b0;
  logic [15:0] start_addr = '0;
  logic [15:0] end_addr = '0;
  logic [7:0]  rom_data = '0;
  logic        rom_ok = 1'b0;

  logic [3:0]  din, din_lo;
  logic        busy, done, underrun, rom_cs;
  logic        busy_lo, done_lo, underrun_lo, rom_cs_lo;
  logic [15:0] rom_addr, rom_addr_lo;

  logic [7:0]  mem [0:65535];
  int          rom_lat = 3;
  bit          stale_mode = 1'b0;
  logic [15:0] prev_a = '0;
  int          lat_cnt = 0;

  bit          irq_en = 1'b0;
  int          irq_period = 64;
  int          irq_cnt = 0;
  logic [3:0]  din_q[$];
  logic [3:0]  din_lo_q[$];
  logic        done_q[$];
  logic [15:0] addr_q[$];
  int          done_cnt = 0;
  int          done_lo_cnt = 0;
  bit          cs_prev = 1'b0;

  int          tests = 0;
  int          fails = 0;

  jt5205_feeder #(.AW(16), .HIGH_FIRST(1)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .start_addr(start_addr), .end_addr(end_addr), .irq(irq),
    .din(din), .busy(busy), .done(done), .underrun(underrun),
    .rom_addr(rom_addr), .rom_cs(rom_cs), .rom_data(rom_data), .rom_ok(rom_ok)
  );

  jt5205_feeder #(.AW(16), .HIGH_FIRST(0)) dut_lo (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .start_addr(start_addr), .end_addr(end_addr), .irq(irq),
    .din(din_lo), .busy(busy_lo), .done(done_lo), .underrun(underrun_lo),
    .rom_addr(rom_addr_lo), .rom_cs(rom_cs_lo), .rom_data(rom_data), .rom_ok(rom_ok)
  );

  always #5 clk = ~clk;

  // ROM answers a fixed number of cycles into a request; in stale mode rom_ok
  // never drops and data trails the address by one cycle.
  always @(posedge clk) begin
    rom_data <= mem[rom_addr];
    if (rom_cs && rom_addr == prev_a) lat_cnt <= lat_cnt + 1;
    else lat_cnt <= 0;
    prev_a <= rom_addr;
    rom_ok <= stale_mode ? 1'b1 : (rom_cs && lat_cnt >= rom_lat);
  end

  // Records the response to each strobe and drives the next strobe
  initial begin
    forever begin
      @(negedge clk);
      if (irq) begin
        din_q.push_back(din);
        din_lo_q.push_back(din_lo);
        done_q.push_back(done);
      end
      if (done) done_cnt++;
      if (done_lo) done_lo_cnt++;
      if (rom_cs && !cs_prev) addr_q.push_back(rom_addr);
      cs_prev = rom_cs;
      if (irq_en) begin
        if (irq_cnt >= irq_period - 1) begin
          irq = 1'b1;
          irq_cnt = 0;
        end else begin
          irq = 1'b0;
          irq_cnt++;
        end
      end else begin
        irq = 1'b0;
        irq_cnt = 0;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulseStart(input logic [15:0] sa, input logic [15:0] ea);
    @(negedge clk);
    din_q.delete();
    din_lo_q.delete();
    done_q.delete();
    addr_q.delete();
    done_cnt = 0;
    done_lo_cnt = 0;
    start_addr = sa;
    end_addr = ea;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic applyStimulus(input logic [15:0] sa, input logic [15:0] ea,
                               input int period, input int max_irq, input int timeout);
    int cyc;
    pulseStart(sa, ea);
    irq_period = period;
    irq_en = 1'b1;
    cyc = 0;
    while (done_cnt == 0 && din_q.size() < max_irq && cyc < timeout) begin
      @(negedge clk);
      cyc++;
    end
    irq_en = 1'b0;
    checkOutput("run in time", 32'(cyc < timeout), 1);
    repeat (3) @(negedge clk);
  endtask

  // Expected nibbles packed MSB-first in exp, n strobes in total
  task automatic checkDin(input string tag, input bit lo, input logic [31:0] exp, input int n);
    checkOutput({tag, " strobes"}, lo ? din_lo_q.size() : din_q.size(), n);
    for (int i = 0; i < n; i++) begin
      logic [3:0] e;
      logic [3:0] g;
      e = 4'(exp >> (4 * (n - 1 - i)));
      g = 4'bx;
      if (lo && i < din_lo_q.size()) g = din_lo_q[i];
      if (!lo && i < din_q.size()) g = din_q[i];
      checkOutput($sformatf("%s din[%0d]", tag, i), g, e);
    end
  endtask

  initial begin
    int cyc;
    int zeros;
    logic [31:0] nz;
    int nz_cnt;

    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0010] = 8'h12; mem[16'h0011] = 8'h34; mem[16'h0012] = 8'h56;
    mem[16'h00FF] = 8'hA7;
    mem[16'hFFFF] = 8'h9C; mem[16'h0000] = 8'h3E;
    mem[16'h0200] = 8'h12; mem[16'h0201] = 8'h34;
    mem[16'h0300] = 8'h5A; mem[16'h0301] = 8'hC3; mem[16'h0302] = 8'h7E;

    repeat (3) @(negedge clk);
    checkOutput("reset din", din, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset rom_cs", rom_cs, 0);
    checkOutput("reset rom_addr", rom_addr, 0);
    rst = 1'b1;

    // Basic playback
    rom_lat = 3;
    applyStimulus(16'h0010, 16'h0012, 64, 20, 2000);
    checkDin("basic", 1'b0, 32'h1234560, 7);
    checkOutput("basic done strobe", done_q.size() == 7 ? done_q[6] : 1'bx, 1);
    checkOutput("basic done count", done_cnt, 1);
    checkOutput("basic busy", busy, 0);
    checkOutput("basic underrun", underrun, 0);

    // Single byte, both nibble orders
    applyStimulus(16'h00FF, 16'h00FF, 64, 20, 1000);
    checkDin("single", 1'b0, 32'hA70, 3);
    checkDin("single lo", 1'b1, 32'h7A0, 3);
    checkOutput("single done count", done_cnt, 1);
    checkOutput("single lo done count", done_lo_cnt, 1);
    checkOutput("single lo busy", busy_lo, 0);
    checkOutput("single lo underrun", underrun_lo, 0);
    checkOutput("single lo rom_cs", rom_cs_lo, 0);
    checkOutput("single lo rom_addr", rom_addr_lo, 16'h00FF);

    // Address wrap
    applyStimulus(16'hFFFF, 16'h0000, 64, 20, 1000);
    checkDin("wrap", 1'b0, 32'h9C3E0, 5);
    checkOutput("wrap fetches", addr_q.size(), 2);
    checkOutput("wrap addr0", addr_q.size() > 0 ? addr_q[0] : 16'hx, 16'hFFFF);
    checkOutput("wrap addr1", addr_q.size() > 1 ? addr_q[1] : 16'hx, 16'h0000);
    checkOutput("wrap done count", done_cnt, 1);

    // Slow ROM: starved strobes read as zero, playback still completes
    rom_lat = 100;
    applyStimulus(16'h0200, 16'h0201, 40, 100, 3000);
    nz = '0;
    nz_cnt = 0;
    zeros = 0;
    foreach (din_q[i]) begin
      if (din_q[i] == 4'h0) zeros++;
      else begin
        nz = (nz << 4) | 32'(din_q[i]);
        nz_cnt++;
      end
    end
    checkOutput("slow nibbles", nz, 32'h1234);
    checkOutput("slow nibble count", nz_cnt, 4);
    checkOutput("slow starved", 32'(zeros >= 2), 1);
    checkOutput("slow underrun", underrun, 1);
    checkOutput("slow done count", done_cnt, 1);
    rom_lat = 3;

    // Stale rom_ok: data trails the address by a cycle
    stale_mode = 1'b1;
    applyStimulus(16'h0300, 16'h0302, 64, 20, 2000);
    checkDin("stale", 1'b0, 32'h5AC37E0, 7);
    checkOutput("stale done count", done_cnt, 1);
    stale_mode = 1'b0;
    repeat (3) @(negedge clk);

    // Stop mid-sample with a fetch outstanding
    pulseStart(16'h0010, 16'h0012);
    irq_period = 64;
    irq_en = 1'b1;
    cyc = 0;
    while (din_q.size() < 2 && cyc < 500) begin @(negedge clk); cyc++; end
    cyc = 0;
    while (!rom_cs && cyc < 50) begin @(negedge clk); cyc++; end
    checkOutput("stop fetch seen", rom_cs, 1);
    checkOutput("stop din before", din, 2);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    checkOutput("stop busy", busy, 0);
    checkOutput("stop rom_cs", rom_cs, 0);
    checkOutput("stop din", din, 0);
    repeat (150) @(negedge clk);
    irq_en = 1'b0;
    checkOutput("stop no done", done_cnt, 0);
    checkOutput("stop idle din", din, 0);
    checkOutput("stop idle rom_cs", rom_cs, 0);

    // Reset during a fetch
    pulseStart(16'h0010, 16'h0012);
    cyc = 0;
    while (!rom_cs && cyc < 50) begin @(negedge clk); cyc++; end
    checkOutput("rst fetch seen", rom_cs, 1);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst din", din, 0);
    checkOutput("rst busy", busy, 0);
    checkOutput("rst done", done, 0);
    checkOutput("rst underrun", underrun, 0);
    checkOutput("rst rom_cs", rom_cs, 0);
    checkOutput("rst rom_addr", rom_addr, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // start and stop together: stop wins
    start_addr = 16'h0010;
    end_addr = 16'h0012;
    start = 1'b1;
    stop = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop = 1'b0;
    checkOutput("start+stop busy", busy, 0);
    repeat (5) @(negedge clk);
    checkOutput("start+stop rom_cs", rom_cs, 0);
    checkOutput("start+stop busy later", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
